ram_port_arbiter: RTL

- Two-requester arbiter that shares one single-port, synchronous-read RAM (AWIDTH/DWIDTH parameterised, write on rising edge, read address latched on the edge, data valid the following cycle).
- Grants one access per cycle, round-robin by default, with an optional bounded lock so one requester can take back-to-back bursts.
- Drives the RAM's addr/din/we and routes the one-cycle-late read data back to the requester that issued the read.

---
 rtl/ram_port_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Shares one single-port, synchronous-read RAM between two requesters.
//   One access is granted per cycle: round-robin by default, with an optional
//   lock that lets the current owner take up to MAX_BURST back-to-back grants
//   while the other side is waiting. Read data comes back one cycle after the
//   grant and is steered to the requester that issued the read.
//
// Ports
//   clock, reset          rising-edge clock, synchronous active-high reset
//   req0/1, lock0/1       access request / keep-ownership request
//   we0/1, addr0/1, din0/1  access type, address and write data
//   gnt0/1                access accepted this cycle (combinational)
//   rvalid0/1, rdata0/1   read return, one cycle after the read grant
//   ram_addr, ram_din, ram_we  RAM drive (all zero when nothing is granted)
//   ram_dout              RAM read data, valid the cycle after the address
module ram_port_arbiter #(
  parameter int AWIDTH    = 3,
  parameter int DWIDTH    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic              we0,
  input  logic              we1,
  input  logic [AWIDTH-1:0] addr0,
  input  logic [AWIDTH-1:0] addr1,
  input  logic [DWIDTH-1:0] din0,
  input  logic [DWIDTH-1:0] din1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DWIDTH-1:0] rdata0,
  output logic [DWIDTH-1:0] rdata1,
  output logic [AWIDTH-1:0] ram_addr,
  output logic [DWIDTH-1:0] ram_din,
  output logic              ram_we,
  input  logic [DWIDTH-1:0] ram_dout
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] BURST_LIMIT = CW'(MAX_BURST);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

  state_t            state_reg, state_next;
  logic              prio_reg, prio_next;
  logic [CW-1:0]     burst_cnt_reg, burst_cnt_next;
  logic              rd_pend_reg, rd_id_reg;

  logic [1:0]        req_vec, lock_vec, gnt_vec, rvalid_vec;
  logic [DWIDTH-1:0] rdata_arr [2];
  logic              gnt_any, gnt_id, fresh_grant, owner, other, owned;
  logic              rd_issue;

  assign req_vec  = {req1, req0};
  assign lock_vec = {lock1, lock0};

  // Next-state / grant selection
  always_comb begin
    state_next     = state_reg;
    prio_next      = prio_reg;
    burst_cnt_next = burst_cnt_reg;
    gnt_any        = 1'b0;
    gnt_id         = 1'b0;
    fresh_grant    = 1'b0;
    owned          = (state_reg == OWN0) || (state_reg == OWN1);
    owner          = (state_reg == OWN1);
    other          = ~owner;

    if (owned && req_vec[owner]) begin
      gnt_any = 1'b1;
      if (req_vec[other] && burst_cnt_reg == BURST_LIMIT) begin
        // Burst exhausted with the other side waiting: hand over, and treat
        // it exactly like a fresh arbitration win for the other side.
        gnt_id      = other;
        fresh_grant = 1'b1;
      end else begin
        gnt_id = owner;
        if (burst_cnt_reg != BURST_LIMIT)
          burst_cnt_next = burst_cnt_reg + 1'b1;
        if (!lock_vec[owner]) begin
          state_next     = IDLE;
          burst_cnt_next = '0;
        end
      end
    end else begin
      // IDLE, or the owner dropped its request: plain round-robin this cycle.
      state_next     = IDLE;
      burst_cnt_next = '0;
      if (req_vec != 2'b00) begin
        gnt_any     = 1'b1;
        fresh_grant = 1'b1;
        gnt_id      = (req_vec == 2'b11) ? prio_reg : req_vec[1];
      end
    end

    if (fresh_grant) begin
      prio_next = ~gnt_id;
      if (lock_vec[gnt_id]) begin
        state_next     = gnt_id ? OWN1 : OWN0;
        burst_cnt_next = CW'(1);
      end else begin
        state_next     = IDLE;
        burst_cnt_next = '0;
      end
    end
  end

  // Per-requester grant and read-return steering; everything is forced low
  // while reset is asserted so a read granted just before reset is dropped.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      assign gnt_vec[gi]    = !reset && gnt_any && (gnt_id == 1'(gi));
      assign rvalid_vec[gi] = !reset && rd_pend_reg && (rd_id_reg == 1'(gi));
      assign rdata_arr[gi]  = rvalid_vec[gi] ? ram_dout : '0;
    end
  endgenerate

  assign gnt0    = gnt_vec[0];
  assign gnt1    = gnt_vec[1];
  assign rvalid0 = rvalid_vec[0];
  assign rvalid1 = rvalid_vec[1];
  assign rdata0  = rdata_arr[0];
  assign rdata1  = rdata_arr[1];

  always_comb begin
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    if (gnt_vec[0]) begin
      ram_we   = we0;
      ram_addr = addr0;
      ram_din  = din0;
    end else if (gnt_vec[1]) begin
      ram_we   = we1;
      ram_addr = addr1;
      ram_din  = din1;
    end
  end

  assign rd_issue = (gnt_vec != 2'b00) && !ram_we;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= IDLE;
      prio_reg      <= 1'b0;
      burst_cnt_reg <= '0;
      rd_pend_reg   <= 1'b0;
      rd_id_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      prio_reg      <= prio_next;
      burst_cnt_reg <= burst_cnt_next;
      rd_pend_reg   <= rd_issue;
      rd_id_reg     <= gnt_vec[1];
    end
  end

endmodule
